serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to add a and b; sampled on rising clk edge.
REQ-005 a  input  WIDTH  operand A; captured only on an accepted start.
REQ-006 b  input  WIDTH  operand B; captured only on an accepted start.
REQ-007 busy  output  1  high while an addition is in progress.
REQ-008 done  output  1  one-cycle pulse; sum/carry hold the new result.
REQ-009 sum  output  WIDTH  registered result, (a+b) mod 2^WIDTH.
REQ-010 carry  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-011 The block SHALL compute a+b bit-serially, LSB first, one bit per clk cycle, through a single full_adder instance.
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 Transitions: IDLE->RUN on start=1; RUN->DONE after the WIDTH-th bit; DONE->RUN on start=1, else DONE->IDLE.
REQ-014 An accepted start (in IDLE or DONE) SHALL latch a, b into internal shift registers, clear the carry register and clear the bit counter.
REQ-015 start asserted in RUN SHALL be ignored; the operands are not re-latched and the operation is not extended.
REQ-016 Each RUN cycle: full_adder inputs are shift_a[0], shift_b[0], carry register; the sum bit enters the MSB of a partial-sum register that shifts right; the carry-out is written to the carry register; shift_a/shift_b shift right; counter increments.
REQ-017 Counter width SHALL be clog2(WIDTH+1); RUN ends when counter reaches WIDTH-1 in that cycle, with no wrap-around.
REQ-018 busy SHALL equal 1 exactly in RUN.
REQ-019 done SHALL equal 1 exactly in DONE; it lasts one cycle per operation.
REQ-020 Latency: start sampled at edge k → busy high for cycles k+1..k+WIDTH → done high in cycle k+WIDTH+1.
REQ-021 sum and carry SHALL change only on the edge entering DONE and SHALL hold the previous result throughout RUN.
REQ-022 start in the DONE cycle SHALL be accepted: busy rises the following cycle with no IDLE cycle in between, and sum/carry stay stable until the next completion.
REQ-023 a and b SHALL be don't-care outside the start-acceptance edge.

Reset
REQ-024 rst=1 at a clk edge SHALL force state=IDLE, busy=0, done=0, sum=0, carry=0, counter=0, and clear the internal carry/shift registers.
REQ-025 rst during RUN SHALL abort the operation without a done pulse, and SHALL clear sum and carry.
REQ-026 rst SHALL take priority over start in the same cycle.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-028 One sub-module SHALL exist: full_adder, built from two half_adder instances plus an OR of their carries; it is purely combinational.
REQ-029 All state SHALL be held in serial_adder; no latches and no combinational loops.

Verification
REQ-030 WIDTH=8, a=0x00, b=0x00, start pulse → done exactly 9 cycles after the start edge, sum=0x00, carry=0.
REQ-031 a=0xFF, b=0x01 → sum=0x00, carry=1; a=0xA5, b=0x5A → sum=0xFF, carry=0.
REQ-032 Start 0x10+0x20, then hold start=1 with a=0xFF, b=0xFF during RUN → the only result is sum=0x30, carry=0; busy width stays 8 cycles.
REQ-033 Start 0x0F+0x01, then assert start with 0x80+0x80 in the done cycle → done at 0x10/0, then busy the next cycle, then done at 0x00/1 nine cycles later.
REQ-034 Assert rst 3 cycles into RUN → next cycle busy=0, done=0, sum=0x00, carry=0; no done pulse follows.
REQ-035 Random regression of 1000 operand pairs → sum/carry match {carry,sum}=a+b; done count equals accepted-start count.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the controller state encoding and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half adders; purely combinational.
// half_adder: x, y -> s, c.  full_adder: a, b, ci -> s, co.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .x (a),
        .y (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .x (s0),
        .y (ci),
        .s (s),
        .c (c1)
    );

    assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a+b LSB first, one bit per clock, via one full_adder.
// Ports: clk, rst (sync, active-high), start, a, b in; busy, done, sum, carry out.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] psum;
    logic             cy;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] psum_nx;

    full_adder u_fa (
        .a  (shift_a[0]),
        .b  (shift_b[0]),
        .ci (cy),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt == LAST);

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 is at the LSB.
    assign psum_nx = {fa_s, psum[WIDTH-1:1]};

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_a <= '0;
            shift_b <= '0;
            psum    <= '0;
            cy      <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            carry   <= 1'b0;
        end else if (accept) begin
            shift_a <= a;
            shift_b <= b;
            psum    <= '0;
            cy      <= 1'b0;
            cnt     <= '0;
        end else if (state == RUN) begin
            shift_a <= {1'b0, shift_a[WIDTH-1:1]};
            shift_b <= {1'b0, shift_b[WIDTH-1:1]};
            psum    <= psum_nx;
            cy      <= fa_co;
            cnt     <= cnt + CW'(1);
            // Result registers move only on the edge that enters DONE.
            if (last_bit) begin
                sum   <= psum_nx;
                carry <= fa_co;
            end
        end
    end

endmodule
